// File: rtl/approx_mult_accumulator.sv
// ============================================================================
// approx_mult_accumulator
//
// Packet accumulator for the 8-bit products of the 4x4 approximate compressor
// multiplier. Products arrive as a valid/ready stream and are summed into
// packet totals (dot products). A packet closes on in_last or after MAX_TERMS
// accepted terms. Each total is then presented, with its term count and an
// overflow flag, on a valid/ready output.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. The source holds its payload stable
// while valid is high and ready is low. This block never makes in_ready
// depend on in_valid, and never makes out_valid depend on out_ready.
//
// Parameters
//   PROD_W     product width (8)
//   ACC_W      accumulator / out_data width (16), must be >= PROD_W
//   MAX_TERMS  forced packet close after this many terms (16), must be >= 1
//   CNT_W      width of out_count, $clog2(MAX_TERMS+1)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   product beat valid
//   in_ready   block can accept a beat (low during rst, HOLD and bubble)
//   in_data    unsigned product
//   in_last    final beat of the current packet
//   out_valid  packet sum valid
//   out_ready  downstream accepts the sum
//   out_data   packet sum
//   out_count  number of terms in the sum
//   out_ovf    sum exceeded 2^ACC_W-1 at some beat of the packet
//   dbg_state  current FSM state (0 = ACCUM, 1 = HOLD)
//
// Build option
//   APPROX_ACC_SATURATE_EN  defined: on carry out the accumulator clamps to
//                           2^ACC_W-1 for the rest of the packet.
//                           undefined: modulo 2^ACC_W wrap-around.
//   out_ovf reports overflow in both builds.
// ============================================================================
module approx_mult_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              dbg_state
);

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_data;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_accept;
    logic [ACC_W:0]     w_ext;
    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_close;
    logic               w_ovf_next;
    logic [ACC_W-1:0]   w_acc_next;

    // r_in_ready is the registered "ACCUM and not in the post-HOLD bubble"
    // flag; rst masks it combinationally so in_ready is low during reset.
    assign in_ready   = r_in_ready && !rst;
    assign w_accept   = in_valid && in_ready;

    // Zero-extend to ACC_W+1 so bit ACC_W of the sum is the carry out.
    assign w_ext      = {{(ACC_W + 1 - PROD_W){1'b0}}, in_data};
    assign w_sum      = {1'b0, r_acc} + w_ext;
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_close    = w_accept && (in_last || (w_cnt_next == CNT_W'(MAX_TERMS)));
    assign w_ovf_next = r_ovf | w_sum[ACC_W];

`ifdef APPROX_ACC_SATURATE_EN
    // Once any carry has occurred in this packet the total stays clamped.
    assign w_acc_next = w_ovf_next ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_close) begin
                        r_out_data  <= w_acc_next;
                        r_out_count <= w_cnt_next;
                        r_out_ovf   <= w_ovf_next;
                        r_out_valid <= 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_HOLD;
                    end else if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_ovf <= w_ovf_next;
                    end
                end
                S_HOLD: begin
                    // r_in_ready stays low here, so the cycle after the
                    // output handshake is a bubble with in_ready=0.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_ACCUM;
                    end
                end
                default: begin
                    r_state <= S_ACCUM;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_approx_mult_accumulator.sv
// Bench for approx_mult_accumulator: two instances share one input stream,
// one at ACC_W=16 (default) and one at ACC_W=10 so overflow is exercised.
module tb_approx_mult_accumulator;

    localparam int PROD_W    = 8;
    localparam int MAX_TERMS = 16;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);
    localparam int AW_A      = 16;
    localparam int AW_B      = 10;
    localparam int EA_W      = AW_A + CNT_W + 1;
    localparam int EB_W      = AW_B + CNT_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              in_valid = 1'b0;
    logic [PROD_W-1:0] in_data  = '0;
    logic              in_last  = 1'b0;
    logic              out_ready = 1'b1;

    logic              a_in_ready, a_out_valid, a_out_ovf, a_dbg_state;
    logic [AW_A-1:0]   a_out_data;
    logic [CNT_W-1:0]  a_out_count;
    logic              b_in_ready, b_out_valid, b_out_ovf, b_dbg_state;
    logic [AW_B-1:0]   b_out_data;
    logic [CNT_W-1:0]  b_out_count;

    approx_mult_accumulator #(.PROD_W(PROD_W), .ACC_W(AW_A), .MAX_TERMS(MAX_TERMS)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_count(a_out_count),
        .out_ovf(a_out_ovf), .dbg_state(a_dbg_state)
    );

    approx_mult_accumulator #(.PROD_W(PROD_W), .ACC_W(AW_B), .MAX_TERMS(MAX_TERMS)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_count(b_out_count),
        .out_ovf(b_out_ovf), .dbg_state(b_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EA_W-1:0] exp_a_q[$];
    logic [EB_W-1:0] exp_b_q[$];
    logic [EA_W-1:0] ea;
    logic [EB_W-1:0] eb;
    int checks = 0;
    int errors = 0;

    int  m_sum = 0;
    int  m_cnt = 0;
    bit  rand_ready = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet total as seen at the output for a w-bit accumulator.
    function automatic int model_out(input int sum, input int w);
        int maxv;
        maxv = (1 << w) - 1;
        if (sum <= maxv) return sum;
`ifdef APPROX_ACC_SATURATE_EN
        return maxv;
`else
        return sum % (1 << w);
`endif
    endfunction

    task automatic model_accept(input int d, input bit last);
        m_sum += d;
        m_cnt++;
        if (last || m_cnt == MAX_TERMS) begin
            exp_a_q.push_back({AW_A'(model_out(m_sum, AW_A)), CNT_W'(m_cnt), (m_sum > (1 << AW_A) - 1)});
            exp_b_q.push_back({AW_B'(model_out(m_sum, AW_B)), CNT_W'(m_cnt), (m_sum > (1 << AW_B) - 1)});
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic model_reset();
        m_sum = 0;
        m_cnt = 0;
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    // Monitor: compare every completed output handshake against the queues.
    always @(negedge clk) begin
        if (!rst && a_out_valid && out_ready) begin
            if (exp_a_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon_a_unexpected actual=%0h expected=none", a_out_data);
            end else begin
                ea = exp_a_q.pop_front();
                check("mon_a_data",  a_out_data,  ea[EA_W-1 -: AW_A]);
                check("mon_a_count", a_out_count, ea[CNT_W:1]);
                check("mon_a_ovf",   a_out_ovf,   ea[0]);
            end
        end
        if (!rst && b_out_valid && out_ready) begin
            if (exp_b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon_b_unexpected actual=%0h expected=none", b_out_data);
            end else begin
                eb = exp_b_q.pop_front();
                check("mon_b_data",  b_out_data,  eb[EB_W-1 -: AW_B]);
                check("mon_b_count", b_out_count, eb[CNT_W:1]);
                check("mon_b_ovf",   b_out_ovf,   eb[0]);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input int d, input bit last, output int acc_cyc);
        in_valid = 1'b1;
        in_data  = PROD_W'(d);
        in_last  = last;
        acc_cyc  = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=no_accept expected=accept data=%0h", d);
        end else begin
            @(posedge clk);
            model_accept(d, last);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input int d, input bit last);
        int t;
        send_beat(d, last, t);
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("post_rst_out_valid", a_out_valid, 0);
        check("post_rst_out_data",  a_out_data,  0);
        check("post_rst_out_count", a_out_count, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1;
        int sat_exp;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready_low", a_in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", a_in_ready, 1);
        check("reset_out_valid", a_out_valid, 0);
        check("reset_out_data", a_out_data, 0);
        check("reset_out_count", a_out_count, 0);
        check("reset_out_ovf", a_out_ovf, 0);
        check("reset_state", a_dbg_state, 0);
        @(posedge clk);
        #1;

        // 1: three beats, last on third
        out_ready = 1'b1;
        send(8'h10, 0);
        send(8'h20, 0);
        send(8'h30, 1);
        @(negedge clk);
        check("t1_out_valid", a_out_valid, 1);
        check("t1_out_data", a_out_data, 16'h0060);
        check("t1_out_count", a_out_count, 3);
        check("t1_out_ovf", a_out_ovf, 0);
        drain();

        // 2: forced close after MAX_TERMS
        for (int i = 0; i < MAX_TERMS; i++) send(8'h01, 0);
        @(negedge clk);
        check("t2_out_valid", a_out_valid, 1);
        check("t2_in_ready_hold", a_in_ready, 0);
        check("t2_state_hold", a_dbg_state, 1);
        check("t2_out_data", a_out_data, 16'h0010);
        check("t2_out_count", a_out_count, 16);
        @(negedge clk);
        check("t2_bubble_in_ready", a_in_ready, 0);
        check("t2_bubble_out_valid", a_out_valid, 0);
        @(negedge clk);
        check("t2_in_ready_back", a_in_ready, 1);
        @(posedge clk);
        #1;

        // 3: backpressure with a pending input beat
        out_ready = 1'b0;
        send(8'h11, 1);
        in_valid = 1'b1;
        in_data  = 8'h22;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_out_valid_stable", a_out_valid, 1);
            check("t3_out_data_stable", a_out_data, 16'h0011);
            check("t3_in_ready_low", a_in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_out_valid_cleared", a_out_valid, 0);
        check("t3_bubble_in_ready", a_in_ready, 0);
        @(negedge clk);
        check("t3_in_ready_back", a_in_ready, 1);
        @(posedge clk);
        model_accept(8'h22, 1);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // 4: overflow on the 10-bit instance
        for (int i = 0; i < 5; i++) send(8'hFF, i == 4);
        @(negedge clk);
`ifdef APPROX_ACC_SATURATE_EN
        sat_exp = 10'h3FF;
`else
        sat_exp = 10'h0FB;
`endif
        check("t4_b_out_data", b_out_data, sat_exp);
        check("t4_b_out_ovf", b_out_ovf, 1);
        check("t4_a_out_data", a_out_data, 16'h04FB);
        check("t4_a_out_ovf", a_out_ovf, 0);
        drain();

        // 5: reset mid-packet, then reset during HOLD
        send(8'hAA, 0);
        send(8'hAA, 0);
        pulse_reset();
        send(8'h05, 1);
        @(negedge clk);
        check("t5_out_data", a_out_data, 16'h0005);
        check("t5_out_count", a_out_count, 1);
        check("t5_out_ovf", a_out_ovf, 0);
        drain();
        out_ready = 1'b0;
        send(8'h33, 1);
        pulse_reset();
        out_ready = 1'b1;

        // 6: back-to-back single-beat packets
        send_beat(8'h07, 1, t0);
        send_beat(8'h09, 1, t1);
        check("t6_beat_spacing", t1 - t0, 3);
        drain();

        // randomized traffic with random backpressure
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        check("final_queue_a_empty", exp_a_q.size(), 0);
        check("final_queue_b_empty", exp_b_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
